dircc_packetiser: RTL
=====================

// Module: dircc_packetiser
// PURPOSE
//  Source end of the DiRCC router stream: turns one parallel message (destination address + byte payload)
//  into an Avalon-ST packet for the router's in_* port. Beat 0 is a header word, followed by ceil(len/4) payload beats.
//  Sits between a device/mailbox and dircc_router; one instance per router input.
// PARAMETERS
//  DATA_WIDTH  32  stream beat width; 4 symbols of 8 bits, first symbol in [31:24]
//  EMPTY_WIDTH 2   width of out_empty
//  ADDR_WIDTH  16  destination address width; carried in header [31:16]
//  MAX_WORDS   8   payload capacity in DATA_WIDTH words (MAX_BYTES = 4*MAX_WORDS = 32)
//  LEN_WIDTH   6   width of msg_len (byte count)
// PORTS
//  clk               in   1                     clock
//  reset             in   1                     synchronous, active-high
//  msg_valid         in   1                     message offered
//  msg_ready         out  1                     message accepted when msg_valid&&msg_ready
//  msg_dest          in   ADDR_WIDTH            destination address
//  msg_len           in   LEN_WIDTH             payload length in bytes
//  msg_payload       in   MAX_WORDS*DATA_WIDTH  byte i at word i/4, lane i%4 (word 0 in LSBs, lane 0 = [31:24])
//  out_ready         in   1                     downstream ready, readyLatency 0
//  out_valid         out  1                     beat valid
//  out_data          out  DATA_WIDTH            beat data
//  out_startofpacket out  1                     first beat (header)
//  out_endofpacket   out  1                     last beat
//  out_empty         out  EMPTY_WIDTH           unused symbols on EOP beat, else 0
//  err_len           out  1                     sticky: a msg_len > MAX_BYTES was accepted
//  pkt_count         out  16                    completed packets (EOP beat accepted), wraps 0xFFFF->0
// BEHAVIOUR
//  Interface: one clock, clk; reset is synchronous and active-high.
//  Reset: state IDLE; msg_ready=1; out_valid=0; out_data, SOP, EOP, empty=0; err_len=0; pkt_count=0.
//  FSM IDLE -> HEADER -> PAYLOAD -> IDLE.
//   IDLE: msg_ready=1, out_valid=0. On accept, latch dest, effective length L, and payload. Go to HEADER.
//   HEADER: out_valid=1, SOP=1, data={dest,L[7:0],8'h00}. If L==0: EOP=1, empty=0.
//    Transfer (out_valid&&out_ready) goes to IDLE if L==0, else to PAYLOAD with beat index 0.
//   PAYLOAD: beat k carries payload word k. The last beat is k==ceil(L/4)-1.
//    On the last beat EOP=1 and empty=(4-L%4)%4. On transfer of the last beat go to IDLE, else k++.
//  L = min(msg_len, MAX_BYTES). If msg_len > MAX_BYTES, set err_len (cleared only by reset).
//  Byte lanes beyond L on the last beat are driven 0.
//  msg_ready is 0 outside IDLE. No same-cycle accept while a packet is in flight.
//   The IDLE cycle after EOP is a mandatory bubble.
//  Latency: accept in cycle N -> header valid in cycle N+1. 1 beat/cycle while out_ready=1.
//  Backpressure: with out_valid=1 and out_ready=0, out_data/SOP/EOP/empty are held stable.
//   out_valid is never deasserted until the beat transfers.
//  Latched payload is immune to msg_* changes after accept.
//  pkt_count increments in the cycle after the EOP transfer.
//  Reset mid-packet abandons the packet: out_valid=0 from the next cycle, no EOP, pkt_count=0.
//  reset has priority over every other event in the same cycle.
// TESTING
//  1. dest=0x0012, len=0, out_ready=1 -> single beat, SOP=EOP=1, data=0x0012_0000, empty=0; pkt_count=1.
//  2. dest=0xABCD, len=5, payload bytes 01..05 -> header 0xABCD_0500, then 0x01020304,
//     then 0x05000000 with EOP and empty=3.
//  3. len=32, bytes 00..1F -> 9 beats on consecutive cycles, last beat 0x1C1D1E1F with empty=0;
//     msg_ready low for 9 cycles, high again 1 cycle after EOP.
//  4. len=6 with out_ready toggling 1,0,0,1,... -> every beat held stable while stalled;
//     beat sequence identical to the unstalled run; msg_* changed after accept has no effect.
//  5. reset asserted during payload beat 1 of an 8-beat packet -> out_valid=0 next cycle,
//     no EOP emitted, msg_ready=1, pkt_count=0.
//  6. len=40 -> header length byte 0x20, 9 beats, err_len=1 and held through the next legal packet.

Source files
------------

// File: rtl/dircc_packetiser.sv
// dircc_packetiser: source end of a DiRCC router stream.
// Accepts one parallel message (destination + up to MAX_WORDS*4 payload bytes) and emits it
// as an Avalon-ST packet: a header beat {dest, len, 8'h00} followed by ceil(len/4) payload beats.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   msg_valid/ready     message handshake (ready only while idle)
//   msg_dest            destination address, carried in header [31:16]
//   msg_len             payload length in bytes (clamped to MAX_BYTES)
//   msg_payload         byte i at word i/4, lane i%4 (word 0 in LSBs, lane 0 = [31:24])
//   out_*               Avalon-ST source, readyLatency 0, all outputs registered
//   err_len             sticky: an oversize msg_len was accepted
//   pkt_count           packets whose EOP beat has transferred, wrapping
module dircc_packetiser #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned EMPTY_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned MAX_WORDS   = 8,
  parameter int unsigned LEN_WIDTH   = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            msg_valid,
  output logic                            msg_ready,
  input  logic [ADDR_WIDTH-1:0]           msg_dest,
  input  logic [LEN_WIDTH-1:0]            msg_len,
  input  logic [MAX_WORDS*DATA_WIDTH-1:0] msg_payload,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_startofpacket,
  output logic                            out_endofpacket,
  output logic [EMPTY_WIDTH-1:0]          out_empty,
  output logic                            err_len,
  output logic [15:0]                     pkt_count
);

  localparam int unsigned SYMBOLS   = DATA_WIDTH / 8;
  localparam int unsigned MAX_BYTES = SYMBOLS * MAX_WORDS;
  localparam int unsigned WIDX_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  // One extra bit so the word count itself (up to MAX_WORDS) is representable.
  localparam int unsigned IDX_W     = WIDX_W + 1;

  typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

  state_e                          state;
  logic [LEN_WIDTH-1:0]            len_q;
  logic [MAX_WORDS*DATA_WIDTH-1:0] payload_q;
  logic [IDX_W-1:0]                beat_idx;

  logic                            len_over;
  logic [LEN_WIDTH-1:0]            eff_len;
  logic [DATA_WIDTH-1:0]           header_word;
  logic [31:0]                     len_ext;
  logic [IDX_W-1:0]                nwords;
  logic [IDX_W-1:0]                next_idx;
  logic [DATA_WIDTH-1:0]           next_word;
  logic                            next_is_last;
  logic [EMPTY_WIDTH-1:0]          empty_last;

  // Accept-side decode, taken straight from msg_* so the header is ready one cycle after accept.
  always_comb begin
    len_over    = 32'(msg_len) > MAX_BYTES;
    eff_len     = len_over ? LEN_WIDTH'(MAX_BYTES) : msg_len;
    header_word = DATA_WIDTH'({msg_dest, 8'(eff_len), 8'h00});
  end

  // Next payload beat, built from the latched copy so later msg_* changes cannot leak in.
  always_comb begin
    len_ext      = 32'(len_q);
    nwords       = IDX_W'((len_ext + SYMBOLS - 1) / SYMBOLS);
    next_idx     = (state == StPayload) ? beat_idx + IDX_W'(1) : '0;
    next_word    = payload_q[next_idx[WIDX_W-1:0]*DATA_WIDTH +: DATA_WIDTH];
    // Lanes past the message length are zeroed on the final beat.
    for (int unsigned j = 0; j < SYMBOLS; j++) begin
      if (32'(next_idx) * SYMBOLS + j >= len_ext) begin
        next_word[DATA_WIDTH-1-8*j -: 8] = 8'h00;
      end
    end
    next_is_last = (next_idx == nwords - IDX_W'(1));
    empty_last   = EMPTY_WIDTH'((SYMBOLS - (len_ext % SYMBOLS)) % SYMBOLS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= StIdle;
      len_q             <= '0;
      payload_q         <= '0;
      beat_idx          <= '0;
      msg_ready         <= 1'b1;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      err_len           <= 1'b0;
      pkt_count         <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (msg_valid) begin
            len_q             <= eff_len;
            payload_q         <= msg_payload;
            beat_idx          <= '0;
            if (len_over) err_len <= 1'b1;
            msg_ready         <= 1'b0;
            out_valid         <= 1'b1;
            out_data          <= header_word;
            out_startofpacket <= 1'b1;
            out_endofpacket   <= (eff_len == '0);
            out_empty         <= '0;
            state             <= StHeader;
          end
        end
        StHeader, StPayload: begin
          if (out_ready) begin
            if (out_endofpacket) begin
              // Return to idle; the following cycle is the mandatory bubble.
              state             <= StIdle;
              msg_ready         <= 1'b1;
              out_valid         <= 1'b0;
              out_data          <= '0;
              out_startofpacket <= 1'b0;
              out_endofpacket   <= 1'b0;
              out_empty         <= '0;
              pkt_count         <= pkt_count + 16'd1;
            end else begin
              state             <= StPayload;
              beat_idx          <= next_idx;
              out_data          <= next_word;
              out_startofpacket <= 1'b0;
              out_endofpacket   <= next_is_last;
              out_empty         <= next_is_last ? empty_last : '0;
            end
          end
        end
        default: begin
          state     <= StIdle;
          msg_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
